exe_stage: RTL and testbench

- Execute stage of the 5-stage MIPS pipeline. Sits directly downstream of the ID/EXE pipeline register and consumes its registered outputs.
- Resolves operand forwarding from the ADEPEN/BDEPEN/STOREDEPEN codes and performs the ALU operation.
- Registers the result, store data and control into the EXE/MEM boundary, so the block contains the EXE/MEM pipeline register.
- Supports pipeline stall (hold) and flush (bubble insertion).

---
 rtl/exe_stage.sv | 134 +++++++++++++
 tb/tb_exe_stage.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/exe_stage.sv
// Execute stage of the 5-stage MIPS pipeline: operand forwarding, ALU, and the
// EXE/MEM pipeline register with stall (hold) and flush (bubble) control.
module exe_stage #(
  parameter int              WIDTH      = 32,
  parameter logic [WIDTH-1:0] RST_PC_NOP = '0
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             stall,
  input  logic             flush,
  input  logic [2:0]       aluc_exe,
  input  logic             aluimm_exe,
  input  logic             shift_exe,
  input  logic             m2reg_exe,
  input  logic             wmem_exe,
  input  logic             wreg_exe,
  input  logic [4:0]       wn_exe,
  input  logic [WIDTH-1:0] ra_exe,
  input  logic [WIDTH-1:0] rb_exe,
  input  logic [WIDTH-1:0] imm_exe,
  input  logic [1:0]       ADEPEN_exe,
  input  logic [1:0]       BDEPEN_exe,
  input  logic [1:0]       STOREDEPEN_exe,
  input  logic [WIDTH-1:0] wdata_wb,
  output logic [WIDTH-1:0] alu_mem,
  output logic [WIDTH-1:0] store_mem,
  output logic [4:0]       wn_mem,
  output logic             wreg_mem,
  output logic             m2reg_mem,
  output logic             wmem_mem,
  output logic             ovf_mem
);

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLL = 3'b101,
    ALU_SRL = 3'b110,
    ALU_SRA = 3'b111
  } alu_op_e;

  // Code 01 taps our own registered result; code 11 is reserved and falls back to the register file.
  function automatic logic [WIDTH-1:0] fwd_sel(
    input logic [1:0]       sel,
    input logic [WIDTH-1:0] reg_val,
    input logic [WIDTH-1:0] alu_val,
    input logic [WIDTH-1:0] wb_val
  );
    case (sel)
      2'b01:   return alu_val;
      2'b10:   return wb_val;
      default: return reg_val;
    endcase
  endfunction

  logic [WIDTH-1:0] rs_fwd;
  logic [WIDTH-1:0] rt_fwd;
  logic [WIDTH-1:0] store_fwd;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [4:0]       shamt;
  logic [WIDTH-1:0] alu_result;
  logic             alu_ovf;
  alu_op_e          alu_op;

  assign rs_fwd    = fwd_sel(ADEPEN_exe,     ra_exe, alu_mem, wdata_wb);
  assign rt_fwd    = fwd_sel(BDEPEN_exe,     rb_exe, alu_mem, wdata_wb);
  assign store_fwd = fwd_sel(STOREDEPEN_exe, rb_exe, alu_mem, wdata_wb);

  assign op_a   = shift_exe  ? {{(WIDTH-5){1'b0}}, imm_exe[10:6]} : rs_fwd;
  assign op_b   = aluimm_exe ? imm_exe : rt_fwd;
  assign shamt  = op_a[4:0];
  assign sum    = op_a + op_b;
  assign diff   = op_a - op_b;
  assign alu_op = alu_op_e'(aluc_exe);

  // Signed overflow: operands agree in sign (add) or differ (sub) and the result sign flips.
  always_comb begin
    alu_result = '0;
    alu_ovf    = 1'b0;
    case (alu_op)
      ALU_ADD: begin
        alu_result = sum;
        alu_ovf    = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
      end
      ALU_SUB: begin
        alu_result = diff;
        alu_ovf    = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
      end
      ALU_AND: alu_result = op_a & op_b;
      ALU_OR:  alu_result = op_a | op_b;
      ALU_XOR: alu_result = op_a ^ op_b;
      ALU_SLL: alu_result = op_b << shamt;
      ALU_SRL: alu_result = op_b >> shamt;
      ALU_SRA: alu_result = $signed(op_b) >>> shamt;
      default: alu_result = '0;
    endcase
  end

  // EXE/MEM register: reset > flush > stall > load.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      alu_mem   <= '0;
      store_mem <= '0;
      wn_mem    <= '0;
      wreg_mem  <= 1'b0;
      m2reg_mem <= 1'b0;
      wmem_mem  <= 1'b0;
      ovf_mem   <= 1'b0;
    end else if (flush) begin
      alu_mem   <= RST_PC_NOP;
      store_mem <= RST_PC_NOP;
      wn_mem    <= '0;
      wreg_mem  <= 1'b0;
      m2reg_mem <= 1'b0;
      wmem_mem  <= 1'b0;
      ovf_mem   <= 1'b0;
    end else if (!stall) begin
      alu_mem   <= alu_result;
      store_mem <= store_fwd;
      wn_mem    <= wn_exe;
      wreg_mem  <= wreg_exe;
      m2reg_mem <= m2reg_exe;
      wmem_mem  <= wmem_exe;
      ovf_mem   <= alu_ovf;
    end
  end

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: directed scenarios plus random traffic
// compared against an arithmetic reference model of the EXE/MEM outputs.
module tb_exe_stage;

  logic        Clock;
  logic        Reset;
  logic        stall;
  logic        flush;
  logic [2:0]  aluc_exe;
  logic        aluimm_exe;
  logic        shift_exe;
  logic        m2reg_exe;
  logic        wmem_exe;
  logic        wreg_exe;
  logic [4:0]  wn_exe;
  logic [31:0] ra_exe;
  logic [31:0] rb_exe;
  logic [31:0] imm_exe;
  logic [1:0]  ADEPEN_exe;
  logic [1:0]  BDEPEN_exe;
  logic [1:0]  STOREDEPEN_exe;
  logic [31:0] wdata_wb;
  logic [31:0] alu_mem;
  logic [31:0] store_mem;
  logic [4:0]  wn_mem;
  logic        wreg_mem;
  logic        m2reg_mem;
  logic        wmem_mem;
  logic        ovf_mem;

  int total = 0;
  int bad   = 0;

  logic [31:0] e_alu, e_store;
  logic [4:0]  e_wn;
  logic        e_wreg, e_m2reg, e_wmem, e_ovf;

  exe_stage #(.WIDTH(32), .RST_PC_NOP(32'h0)) dut (
    .Clock(Clock), .Reset(Reset), .stall(stall), .flush(flush),
    .aluc_exe(aluc_exe), .aluimm_exe(aluimm_exe), .shift_exe(shift_exe),
    .m2reg_exe(m2reg_exe), .wmem_exe(wmem_exe), .wreg_exe(wreg_exe),
    .wn_exe(wn_exe), .ra_exe(ra_exe), .rb_exe(rb_exe), .imm_exe(imm_exe),
    .ADEPEN_exe(ADEPEN_exe), .BDEPEN_exe(BDEPEN_exe),
    .STOREDEPEN_exe(STOREDEPEN_exe), .wdata_wb(wdata_wb),
    .alu_mem(alu_mem), .store_mem(store_mem), .wn_mem(wn_mem),
    .wreg_mem(wreg_mem), .m2reg_mem(m2reg_mem), .wmem_mem(wmem_mem),
    .ovf_mem(ovf_mem)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic logic [31:0] pick(input logic [1:0] code, input logic [31:0] regv);
    if (code == 2'd1) return e_alu;
    if (code == 2'd2) return wdata_wb;
    return regv;
  endfunction

  // Reference ALU using wide signed arithmetic to decide overflow.
  task automatic modelAlu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output logic ov);
    longint s;
    int amt;
    amt = int'(a % 32);
    ov  = 1'b0;
    s   = 0;
    case (op)
      3'd0: begin s = longint'($signed(a)) + longint'($signed(b)); r = s[31:0];
              ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      3'd1: begin s = longint'($signed(a)) - longint'($signed(b)); r = s[31:0];
              ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: begin s = longint'(b) * (64'sd1 <<< amt); r = s[31:0]; end
      3'd6: r = b / (32'd1 << amt);
      default: begin s = longint'($signed(b)) >>> amt; r = s[31:0]; end
    endcase
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".alu"},   alu_mem,          e_alu);
    checkOutput({tag, ".store"}, store_mem,        e_store);
    checkOutput({tag, ".wn"},    32'(wn_mem),      32'(e_wn));
    checkOutput({tag, ".wreg"},  32'(wreg_mem),    32'(e_wreg));
    checkOutput({tag, ".m2reg"}, 32'(m2reg_mem),   32'(e_m2reg));
    checkOutput({tag, ".wmem"},  32'(wmem_mem),    32'(e_wmem));
    checkOutput({tag, ".ovf"},   32'(ovf_mem),     32'(e_ovf));
  endtask

  // One clock edge with the model advanced alongside, then a full output check.
  task automatic applyStimulus(input string tag);
    logic [31:0] a, b, r, st;
    logic ov;
    a  = shift_exe  ? {27'd0, imm_exe[10:6]} : pick(ADEPEN_exe, ra_exe);
    b  = aluimm_exe ? imm_exe : pick(BDEPEN_exe, rb_exe);
    st = pick(STOREDEPEN_exe, rb_exe);
    modelAlu(aluc_exe, a, b, r, ov);
    @(posedge Clock);
    #1;
    if (Reset || flush) begin
      e_alu = 32'd0; e_store = 32'd0; e_wn = 5'd0;
      e_wreg = 1'b0; e_m2reg = 1'b0; e_wmem = 1'b0; e_ovf = 1'b0;
    end else if (!stall) begin
      e_alu = r; e_store = st; e_wn = wn_exe;
      e_wreg = wreg_exe; e_m2reg = m2reg_exe; e_wmem = wmem_exe; e_ovf = ov;
    end
    checkAll(tag);
  endtask

  task automatic setOp(input logic [2:0] op, input logic [31:0] ra, input logic [31:0] rb);
    aluc_exe = op; ra_exe = ra; rb_exe = rb;
    aluimm_exe = 1'b0; shift_exe = 1'b0;
    ADEPEN_exe = 2'd0; BDEPEN_exe = 2'd0; STOREDEPEN_exe = 2'd0;
  endtask

  initial begin
    e_alu = 32'hDEAD_BEEF; e_store = 32'hDEAD_BEEF; e_wn = 5'h1F;
    e_wreg = 1'b1; e_m2reg = 1'b1; e_wmem = 1'b1; e_ovf = 1'b1;

    // Reset with stall and nonzero inputs
    Reset = 1'b1; stall = 1'b1; flush = 1'b0;
    aluc_exe = 3'd0; aluimm_exe = 1'b0; shift_exe = 1'b0;
    m2reg_exe = 1'b1; wmem_exe = 1'b1; wreg_exe = 1'b1; wn_exe = 5'd7;
    ra_exe = 32'h1234; rb_exe = 32'h5678; imm_exe = 32'h9ABC;
    ADEPEN_exe = 2'd0; BDEPEN_exe = 2'd0; STOREDEPEN_exe = 2'd0; wdata_wb = 32'hAAAA;
    applyStimulus("reset");
    checkOutput("reset_alu_zero", alu_mem, 32'd0);
    Reset = 1'b0; stall = 1'b0;
    m2reg_exe = 1'b0; wmem_exe = 1'b0; wreg_exe = 1'b1; wn_exe = 5'd3;

    setOp(3'd0, 32'h7FFF_FFFF, 32'h1);
    applyStimulus("add_ovf");
    checkOutput("add_ovf_const", alu_mem, 32'h8000_0000);
    checkOutput("add_ovf_flag", 32'(ovf_mem), 32'd1);
    setOp(3'd2, 32'h7FFF_FFFF, 32'h1);
    applyStimulus("and");
    checkOutput("and_const", alu_mem, 32'h1);

    setOp(3'd7, 32'h0, 32'hF000_0000);
    shift_exe = 1'b1; imm_exe = 32'd4 << 6;
    applyStimulus("sra");
    checkOutput("sra_const", alu_mem, 32'hFF00_0000);
    aluc_exe = 3'd6;
    applyStimulus("srl");
    checkOutput("srl_const", alu_mem, 32'h0F00_0000);
    aluc_exe = 3'd5;
    applyStimulus("sll");
    checkOutput("sll_const", alu_mem, 32'h0);

    setOp(3'd0, 32'h10, 32'h0);
    applyStimulus("fwd_seed");
    setOp(3'd0, 32'h999, 32'h5); ADEPEN_exe = 2'd1;
    applyStimulus("fwd_a01");
    checkOutput("fwd_a01_const", alu_mem, 32'h15);
    setOp(3'd3, 32'h0, 32'h3); BDEPEN_exe = 2'd2; wdata_wb = 32'h100;
    applyStimulus("fwd_b10");
    checkOutput("fwd_b10_const", alu_mem, 32'h100);
    setOp(3'd0, 32'h4, 32'h8); STOREDEPEN_exe = 2'd1; wmem_exe = 1'b1;
    applyStimulus("fwd_st01");
    checkOutput("fwd_st01_const", store_mem, 32'h100);
    setOp(3'd1, 32'h50, 32'h20); ADEPEN_exe = 2'd3; BDEPEN_exe = 2'd3; STOREDEPEN_exe = 2'd3;
    applyStimulus("fwd_11");
    checkOutput("fwd_11_const", alu_mem, 32'h30);
    wmem_exe = 1'b0;

    // Stall freezes outputs; forwarding from alu_mem sees the held value
    setOp(3'd0, 32'h10, 32'h0);
    applyStimulus("stall_seed");
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      setOp(3'(i), 32'h1000 + 32'(i), 32'h77); ADEPEN_exe = 2'd1; wn_exe = 5'(i + 9);
      applyStimulus("stall_hold");
      checkOutput("stall_hold_const", alu_mem, 32'h10);
    end
    stall = 1'b0;
    setOp(3'd0, 32'h0, 32'h5); ADEPEN_exe = 2'd1;
    applyStimulus("stall_release");
    checkOutput("stall_release_const", alu_mem, 32'h15);

    // Flush wins over stall
    wreg_exe = 1'b1; wmem_exe = 1'b1; m2reg_exe = 1'b1; stall = 1'b1; flush = 1'b1;
    applyStimulus("flush");
    checkOutput("flush_wreg", 32'(wreg_mem), 32'd0);
    stall = 1'b0; flush = 1'b0;

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      Reset = ($urandom_range(0, 63) == 0);
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 15) == 0);
      aluc_exe = 3'($urandom); aluimm_exe = 1'($urandom); shift_exe = ($urandom_range(0, 3) == 0);
      m2reg_exe = 1'($urandom); wmem_exe = 1'($urandom); wreg_exe = 1'($urandom);
      wn_exe = 5'($urandom);
      ra_exe = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFF0 + 32'($urandom_range(0, 31)) : $urandom;
      rb_exe = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 + 32'($urandom_range(0, 31)) : $urandom;
      imm_exe = $urandom; wdata_wb = $urandom;
      ADEPEN_exe = 2'($urandom); BDEPEN_exe = 2'($urandom); STOREDEPEN_exe = 2'($urandom);
      applyStimulus("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
